divide_arbiter: RTL and testbench
=================================

DIVIDE_ARBITER -- requirements
Module: divide_arbiter

Interface
REQ-001 SHALL have parameter DSIZE, default 24, operand width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters.
REQ-003 SHALL have parameter QSIZE, default 48, quotient width (2*DSIZE).
REQ-004 SHALL have parameter ESIZE, default 6, exponent width.
REQ-005 SHALL have parameter TDEPTH, default 4, max operations outstanding (power of 2).
REQ-006 SHALL have port clock  input  1  single clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port enable  input  1  new grants allowed when 1.
REQ-009 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-010 SHALL have port req_N  input  NREQ*DSIZE  dividends, requester i at bits [i*DSIZE +: DSIZE].
REQ-011 SHALL have port req_D  input  NREQ*DSIZE  divisors, same packing.
REQ-012 SHALL have port req_ready  output  NREQ  one-hot grant; transfer when req_valid[i]&req_ready[i].
REQ-013 SHALL have port res_valid  output  NREQ  one-hot one-cycle result strobe.
REQ-014 SHALL have port res_Q  output  QSIZE  result quotient.
REQ-015 SHALL have port res_EXP  output  ESIZE  result exponent.
REQ-016 SHALL have port res_dz  output  1  result is divide-by-zero.
REQ-017 SHALL have ports div_N, div_D  output  DSIZE each  operands to divider.
REQ-018 SHALL have port div_enable  output  1  issue strobe to divider.
REQ-019 SHALL have ports div_Q (QSIZE), div_EXP (ESIZE), div_VALID (1), div_RDY (1)  input  divider results, result strobe, accept-ready.
REQ-020 SHALL have ports busy  output  1  (tag FIFO non-empty), err  output  1  sticky protocol error.

Function
REQ-021 SHALL grant at most one requester per cycle, combinationally, round-robin from pointer rr (reset 0): first i in rr, rr+1, ... mod NREQ with req_valid[i]=1.
REQ-022 SHALL grant only when enable=1, FIFO count<TDEPTH (pop same cycle not credited), no bypass entry in FIFO, and (div_RDY=1 or selected req_D=0).
REQ-023 SHALL on a grant to i set rr to (i+1) mod NREQ next cycle; rr unchanged without grant.
REQ-024 SHALL on grant with req_D!=0 drive div_enable=1, div_N/div_D = requester i operands same cycle; push tag {bypass=0, id=i}.
REQ-025 SHALL on grant with req_D=0 keep div_enable=0 and push tag {bypass=1, id=i}.
REQ-026 SHALL hold div_enable=0 and div_N/div_D=0 in cycles without a real issue.
REQ-027 SHALL retire in order, one per cycle: div_VALID=1 with head bypass=0 -> pop; next cycle res_valid[id]=1, res_Q=div_Q, res_EXP=div_EXP, res_dz=0 (registered).
REQ-028 SHALL retire head bypass=1 when div_VALID=0 -> pop; next cycle res_valid[id]=1, res_Q=all ones, res_EXP=0, res_dz=1.
REQ-029 SHALL hold res_Q/res_EXP/res_dz at last value and res_valid=0 when nothing retires.
REQ-030 SHALL set err=1 (sticky until reset) on div_VALID=1 with FIFO empty or head bypass=1; result dropped, no pop.
REQ-031 SHALL handle push and pop in same cycle (count unchanged, pointers wrap mod TDEPTH).
REQ-032 SHALL, when enable drops, stop granting; outstanding operations still retire.
REQ-033 SHALL assume divider returns results in issue order; minimum divider latency 1 cycle.

Reset
REQ-034 SHALL on rst=0 asynchronously clear: rr=0, FIFO empty, req_ready=0, res_valid=0, res_Q=0, res_EXP=0, res_dz=0, div_enable=0, div_N=0, div_D=0, busy=0, err=0.
REQ-035 SHALL discard in-flight operations on reset mid-operation; divider shares rst, so no stale div_VALID after release.
REQ-036 SHALL grant no earlier than first rising edge after rst deasserts.

Verification
REQ-037 Single: req_valid=0001, N=6, D=3, divider model latency 5 -> div_enable at cycle 0, res_valid=0001 at cycle 6 with model's Q/EXP, res_dz=0.
REQ-038 Round-robin: req_valid=1111 held, div_RDY=1 -> grants 0001,0010,0100,1000,0001...; stalls after 4 while FIFO full; results retire in issue order.
REQ-039 Zero divisor: requester 2 D=0 behind two real ops -> no div_enable for it, further grants blocked until retired; res_valid=0100, res_Q=all ones, res_EXP=0, res_dz=1 after both real results.
REQ-040 Back-pressure: div_RDY=0 with req_valid=0011 nonzero D -> req_ready=0 until div_RDY=1, then grant 0001.
REQ-041 Protocol error: div_VALID pulse with FIFO empty -> err=1 next cycle, stays 1, no res_valid.
REQ-042 Reset mid-flight: 3 outstanding, rst=0 -> busy=0, res_valid=0 immediately; after release first grant to requester 0.

Source files
------------

// File: rtl/divide_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : divide_arbiter
// Purpose  : Round-robin front end sharing one pipelined divider among NREQ
//            requesters, with in-order tag FIFO and divide-by-zero bypass.
// Revision : 1.0 - initial release
// ============================================================================
module divide_arbiter #(
    parameter int DSIZE  = 24,
    parameter int NREQ   = 4,
    parameter int QSIZE  = 48,
    parameter int ESIZE  = 6,
    parameter int TDEPTH = 4
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_N,
    input  logic [NREQ*DSIZE-1:0] req_D,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       res_valid,
    output logic [QSIZE-1:0]      res_Q,
    output logic [ESIZE-1:0]      res_EXP,
    output logic                  res_dz,
    output logic [DSIZE-1:0]      div_N,
    output logic [DSIZE-1:0]      div_D,
    output logic                  div_enable,
    input  logic [QSIZE-1:0]      div_Q,
    input  logic [ESIZE-1:0]      div_EXP,
    input  logic                  div_VALID,
    input  logic                  div_RDY,
    output logic                  busy,
    output logic                  err
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW1 = IDW + 1;
    localparam int AW  = (TDEPTH > 1) ? $clog2(TDEPTH) : 1;
    localparam int CW  = AW + 1;

    logic [DSIZE-1:0] op_n [NREQ];
    logic [DSIZE-1:0] op_d [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign op_n[i] = req_N[i*DSIZE +: DSIZE];
        assign op_d[i] = req_D[i*DSIZE +: DSIZE];
    end

    logic            live;
    logic [IDW-1:0]  rr;
    logic            found;
    logic [IDW-1:0]  sel;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   byp_cnt;
    logic            tag_byp [TDEPTH];
    logic [IDW-1:0]  tag_id  [TDEPTH];

    always_comb begin : p_select
        logic [IW1-1:0] idx;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr} + IW1'(k);
            if (idx >= IW1'(NREQ)) idx = idx - IW1'(NREQ);
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                sel   = idx[IDW-1:0];
            end
        end
    end

    logic [DSIZE-1:0] sel_n;
    logic [DSIZE-1:0] sel_d;
    logic             d_zero;
    logic             empty;
    logic             full;
    logic             grant;
    logic             issue;
    logic             push_byp;

    assign sel_n  = op_n[sel];
    assign sel_d  = op_d[sel];
    assign d_zero = (sel_d == '0);
    assign empty  = (count == '0);
    assign full   = (count >= CW'(TDEPTH));

    // A zero-divisor grant never reaches the divider, so it ignores div_RDY.
    assign grant    = live && enable && found && !full && (byp_cnt == '0)
                      && (div_RDY || d_zero);
    assign issue    = grant && !d_zero;
    assign push_byp = grant && d_zero;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[sel] = 1'b1;
    end

    assign div_enable = issue;
    assign div_N      = issue ? sel_n : '0;
    assign div_D      = issue ? sel_d : '0;

    logic            head_byp;
    logic [IDW-1:0]  head_id;
    logic            pop_real;
    logic            pop_byp;
    logic            pop;
    logic            proto_err;
    logic [NREQ-1:0] ret_hot;

    assign head_byp  = tag_byp[rd_ptr];
    assign head_id   = tag_id[rd_ptr];
    assign pop_real  = div_VALID && !empty && !head_byp;
    assign pop_byp   = !div_VALID && !empty && head_byp;
    assign pop       = pop_real || pop_byp;
    assign proto_err = div_VALID && (empty || head_byp);

    always_comb begin
        ret_hot = '0;
        if (pop) ret_hot[head_id] = 1'b1;
    end

    logic [AW-1:0]  wr_nxt;
    logic [AW-1:0]  rd_nxt;
    logic [IDW-1:0] rr_nxt;

    assign wr_nxt = (wr_ptr == AW'(TDEPTH-1)) ? '0 : wr_ptr + 1'b1;
    assign rd_nxt = (rd_ptr == AW'(TDEPTH-1)) ? '0 : rd_ptr + 1'b1;
    assign rr_nxt = (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clock) begin
        if (grant) begin
            tag_byp[wr_ptr] <= d_zero;
            tag_id[wr_ptr]  <= sel;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            live      <= 1'b0;
            rr        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            byp_cnt   <= '0;
            err       <= 1'b0;
            res_valid <= '0;
            res_Q     <= '0;
            res_EXP   <= '0;
            res_dz    <= 1'b0;
        end else begin
            live      <= 1'b1;
            if (grant) begin
                rr     <= rr_nxt;
                wr_ptr <= wr_nxt;
            end
            if (pop) rd_ptr <= rd_nxt;
            count     <= count + CW'(grant) - CW'(pop);
            byp_cnt   <= byp_cnt + CW'(push_byp) - CW'(pop_byp);
            if (proto_err) err <= 1'b1;
            res_valid <= ret_hot;
            if (pop_real) begin
                res_Q   <= div_Q;
                res_EXP <= div_EXP;
                res_dz  <= 1'b0;
            end else if (pop_byp) begin
                res_Q   <= '1;
                res_EXP <= '0;
                res_dz  <= 1'b1;
            end
        end
    end

    assign busy = !empty;

endmodule
`default_nettype wire

// File: tb/tb_divide_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_divide_arbiter
// Purpose  : Directed self-checking bench for divide_arbiter with a
//            fixed-latency divider model (Q = N/D, EXP = D[5:0]).
// Revision : 1.0 - initial release
// ============================================================================
module tb_divide_arbiter;

    localparam int DSIZE = 24, NREQ = 4, QSIZE = 48, ESIZE = 6, TDEPTH = 4;
    localparam int LAT   = 5;

    logic                  clock = 1'b0;
    logic                  rst   = 1'b0;
    logic                  enable = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*DSIZE-1:0] req_N = '0;
    logic [NREQ*DSIZE-1:0] req_D = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       res_valid;
    logic [QSIZE-1:0]      res_Q;
    logic [ESIZE-1:0]      res_EXP;
    logic                  res_dz;
    logic [DSIZE-1:0]      div_N;
    logic [DSIZE-1:0]      div_D;
    logic                  div_enable;
    logic [QSIZE-1:0]      div_Q;
    logic [ESIZE-1:0]      div_EXP;
    logic                  div_VALID;
    logic                  div_RDY;
    logic                  busy;
    logic                  err;
    logic                  rdy = 1'b1;
    logic                  inj = 1'b0;

    divide_arbiter #(
        .DSIZE(DSIZE), .NREQ(NREQ), .QSIZE(QSIZE), .ESIZE(ESIZE), .TDEPTH(TDEPTH)
    ) dut (
        .clock(clock), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_N(req_N), .req_D(req_D), .req_ready(req_ready),
        .res_valid(res_valid), .res_Q(res_Q), .res_EXP(res_EXP), .res_dz(res_dz),
        .div_N(div_N), .div_D(div_D), .div_enable(div_enable),
        .div_Q(div_Q), .div_EXP(div_EXP), .div_VALID(div_VALID), .div_RDY(div_RDY),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    // Divider model: fixed latency, shares the reset
    logic [LAT-1:0]   pv;
    logic [QSIZE-1:0] pq [LAT];
    logic [ESIZE-1:0] pe [LAT];

    always @(posedge clock or negedge rst) begin
        if (!rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], div_enable};
            pq[0] <= (div_D != '0) ? QSIZE'(div_N / div_D) : '0;
            pe[0] <= div_D[ESIZE-1:0];
            for (int s = 1; s < LAT; s++) begin
                pq[s] <= pq[s-1];
                pe[s] <= pe[s-1];
            end
        end
    end

    assign div_VALID = pv[LAT-1] | inj;
    assign div_Q     = pq[LAT-1];
    assign div_EXP   = pe[LAT-1];
    assign div_RDY   = rdy;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int i, input int n, input int d);
        req_N[i*DSIZE +: DSIZE] = DSIZE'(n);
        req_D[i*DSIZE +: DSIZE] = DSIZE'(d);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b0;
        #1;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    localparam logic [QSIZE-1:0] ONES = '1;

    logic [3:0]  rr_rdy [13] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h1,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  rr_res [13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
                                 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h1};
    logic [47:0] rr_q   [13] = '{48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd33,
                                 48'd28, 48'd60, 48'd44, 48'd0, 48'd0, 48'd33};
    logic [3:0]  z_rdy  [10] = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    logic [3:0]  z_res  [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h0};
    logic [47:0] z_q    [10] = '{48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd10, 48'd9,
                                 ONES, ONES};
    logic [5:0]  z_e    [10] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd5, 6'd9, 6'd0, 6'd0};
    logic        z_dz   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] seen;

        // Reset state, no grant while held in reset
        for (int i = 0; i < NREQ; i++) set_op(i, 5, 1);
        req_valid = 4'b1111;
        #2;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_Q", 64'(res_Q), 64'(0));
        check("rst_res_EXP", 64'(res_EXP), 64'(0));
        check("rst_res_dz", 64'(res_dz), 64'(0));
        check("rst_div_en", 64'(div_enable), 64'(0));
        check("rst_div_N", 64'(div_N), 64'(0));
        check("rst_div_D", 64'(div_D), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rel_no_grant", 64'(req_ready), 64'(0));
        tick();
        check("rel_first_grant", 64'(req_ready), 64'(4'b0001));
        req_valid = '0;

        // Single operation, latency 5
        set_op(0, 6, 3);
        req_valid = 4'b0001;
        #1;
        check("s_ready", 64'(req_ready), 64'(4'b0001));
        check("s_div_en", 64'(div_enable), 64'(1));
        check("s_div_N", 64'(div_N), 64'(6));
        check("s_div_D", 64'(div_D), 64'(3));
        tick();
        req_valid = '0;
        #1;
        check("s_idle_div_en", 64'(div_enable), 64'(0));
        check("s_idle_div_N", 64'(div_N), 64'(0));
        repeat (4) tick();
        check("s_res_early", 64'(res_valid), 64'(0));
        check("s_busy", 64'(busy), 64'(1));
        tick();
        check("s_res_valid", 64'(res_valid), 64'(4'b0001));
        check("s_res_Q", 64'(res_Q), 64'(2));
        check("s_res_EXP", 64'(res_EXP), 64'(3));
        check("s_res_dz", 64'(res_dz), 64'(0));
        check("s_busy_done", 64'(busy), 64'(0));
        tick();
        check("s_hold_valid", 64'(res_valid), 64'(0));
        check("s_hold_Q", 64'(res_Q), 64'(2));

        // Round-robin with FIFO full stall
        do_reset();
        set_op(0, 100, 3);
        set_op(1, 200, 7);
        set_op(2, 300, 5);
        set_op(3, 400, 9);
        req_valid = 4'b1111;
        for (int c = 0; c < 13; c++) begin
            if (c == 7) req_valid = '0;
            #1;
            check($sformatf("rr_ready_c%0d", c), 64'(req_ready), 64'(rr_rdy[c]));
            check($sformatf("rr_res_c%0d", c), 64'(res_valid), 64'(rr_res[c]));
            if (rr_res[c] != '0)
                check($sformatf("rr_Q_c%0d", c), 64'(res_Q), 64'(rr_q[c]));
            tick();
        end

        // Zero divisor behind two real operations
        do_reset();
        set_op(0, 50, 5);
        set_op(1, 81, 9);
        set_op(2, 7, 0);
        req_valid = 4'b0111;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) req_valid = 4'b0011;
            if (c == 9) req_valid = '0;
            #1;
            check($sformatf("dz_ready_c%0d", c), 64'(req_ready), 64'(z_rdy[c]));
            check($sformatf("dz_res_c%0d", c), 64'(res_valid), 64'(z_res[c]));
            if (c == 2) check("dz_no_div_en", 64'(div_enable), 64'(0));
            if (c >= 6) begin
                check($sformatf("dz_Q_c%0d", c), 64'(res_Q), 64'(z_q[c]));
                check($sformatf("dz_EXP_c%0d", c), 64'(res_EXP), 64'(z_e[c]));
                check($sformatf("dz_flag_c%0d", c), 64'(res_dz), 64'(z_dz[c]));
            end
            tick();
        end

        // Divider back-pressure
        do_reset();
        rdy = 1'b0;
        set_op(0, 9, 3);
        set_op(1, 8, 2);
        req_valid = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp_ready_c%0d", c), 64'(req_ready), 64'(0));
            check($sformatf("bp_div_en_c%0d", c), 64'(div_enable), 64'(0));
            tick();
        end
        rdy = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready), 64'(4'b0001));
        check("bp_release_div_en", 64'(div_enable), 64'(1));
        req_valid = '0;
        tick();

        // Stray divider result with empty FIFO
        do_reset();
        inj = 1'b1;
        #1;
        check("pe_err_before", 64'(err), 64'(0));
        tick();
        inj = 1'b0;
        #1;
        check("pe_err_set", 64'(err), 64'(1));
        check("pe_no_res", 64'(res_valid), 64'(0));
        repeat (3) tick();
        check("pe_err_sticky", 64'(err), 64'(1));
        check("pe_busy", 64'(busy), 64'(0));

        // Reset with three operations outstanding
        do_reset();
        set_op(0, 100, 3);
        set_op(1, 200, 7);
        set_op(2, 300, 5);
        req_valid = 4'b0111;
        repeat (3) tick();
        req_valid = '0;
        #1;
        check("mr_busy_before", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        check("mr_busy_cleared", 64'(busy), 64'(0));
        check("mr_res_cleared", 64'(res_valid), 64'(0));
        check("mr_ready_cleared", 64'(req_ready), 64'(0));
        tick();
        tick();
        rst = 1'b1;
        set_op(3, 40, 4);
        req_valid = 4'b1111;
        #1;
        check("mr_no_early_grant", 64'(req_ready), 64'(0));
        tick();
        check("mr_first_grant", 64'(req_ready), 64'(4'b0001));
        req_valid = '0;
        seen = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            seen = seen | res_valid;
        end
        check("mr_no_stale_res", 64'(seen), 64'(0));
        check("mr_no_err", 64'(err), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
